// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes one operand bit per clock, LSB first,
// and publishes sum, carry_out and signed overflow when the last bit is done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       o_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_res_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  assign o_state = r_state;

  // One full-adder slice on the current LSBs of the shifting operands.
  assign w_bit   = r_a[0] ^ r_b[0] ^ r_c;
  assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last  = (r_cnt == LAST_BIT);

  // New bits enter at the MSB so after WIDTH steps bit 0 holds the LSB result.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_bit;
    end else begin : g_res_wn
      assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Subtraction is a + ~b + 1: operand B is inverted at load, carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= sub ? ~b : b;
      r_c   <= sub;
      r_cnt <= '0;
    end else if (w_step) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res_next;
      r_c   <= w_carry;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        sum       <= w_res_next;
        carry_out <= w_carry;
        overflow  <= r_c ^ w_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances, table vectors,
// hand-written multi-cycle sequences and a done-driven scoreboard.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8, sub8, busy8, done8, co8, ov8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] st8;

  logic       start1, sub1, busy1, done1, co1, ov1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] st1;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp8_q[$];
  logic [2:0] exp1_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       co;
    logic       ov;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic sum;
    logic co;
    logic ov;
  } vec1_t;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8),
    .o_state(st8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1), .overflow(ov1),
    .o_state(st1)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Independent arithmetic reference: widened add of a + b' + cin.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] bb;
    logic [8:0] f;
    logic       ov;
    bb = s ? ~b : b;
    f  = {1'b0, a} + {1'b0, bb} + {8'd0, s};
    ov = (a[7] == bb[7]) && (f[7] != a[7]);
    return {f[7:0], f[8], ov};
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL sb8_spurious: got done with sum=%h, expected no done", sum8);
      end else begin
        logic [9:0] e;
        e = exp8_q.pop_front();
        if ({sum8, co8, ov8} !== e) begin
          errors++;
          $display("FAIL sb8_result: got sum=%h co=%b ov=%b, expected sum=%h co=%b ov=%b",
                   sum8, co8, ov8, e[9:2], e[1], e[0]);
        end
      end
      checks++;
      if (busy8 !== 1'b0) begin
        errors++;
        $display("FAIL sb8_busy_done: got busy=%b with done, expected 0", busy8);
      end
    end
    if (rst_n && done1) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL sb1_spurious: got done with sum=%b, expected no done", sum1);
      end else begin
        logic [2:0] e1;
        e1 = exp1_q.pop_front();
        if ({sum1, co1, ov1} !== e1) begin
          errors++;
          $display("FAIL sb1_result: got sum=%b co=%b ov=%b, expected sum=%b co=%b ov=%b",
                   sum1, co1, ov1, e1[2], e1[1], e1[0]);
        end
      end
    end
  end

  // Checks busy for n cycles after the accept edge, then a lone done pulse.
  task automatic lat_check8(input string name);
    logic ok;
    ok = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (busy8 !== 1'b1 || done8 !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_busy: busy not high for exactly 8 cycles", name);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_lat: got done=%b busy=%b at start+9, expected done=1 busy=0",
               name, done8, busy8);
    end
  endtask

  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [9:0] e);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    exp8_q.push_back(e);
    lat_check8(name);
  endtask

  task automatic op1(input logic a, input logic b, input logic [2:0] e);
    @(negedge clk);
    a1 = a; b1 = b; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    exp1_q.push_back(e);
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_busy: got busy=%b done=%b at start+1, expected 1/0", busy1, done1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_done_lat: got done=%b busy=%b at start+2, expected 1/0", done1, busy1);
    end
  endtask

  vec8_t tbl8[4];
  vec1_t tbl1[4];

  initial begin
    tbl8[0] = '{a: 8'h0F, b: 8'h01, sub: 1'b0, sum: 8'h10, co: 1'b0, ov: 1'b0};
    tbl8[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, co: 1'b1, ov: 1'b0};
    tbl8[2] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, co: 1'b0, ov: 1'b1};
    tbl8[3] = '{a: 8'h05, b: 8'h07, sub: 1'b1, sum: 8'hFE, co: 1'b0, ov: 1'b0};
    tbl1[0] = '{a: 1'b0, b: 1'b0, sum: 1'b0, co: 1'b0, ov: 1'b0};
    tbl1[1] = '{a: 1'b0, b: 1'b1, sum: 1'b1, co: 1'b0, ov: 1'b0};
    tbl1[2] = '{a: 1'b1, b: 1'b0, sum: 1'b1, co: 1'b0, ov: 1'b0};
    tbl1[3] = '{a: 1'b1, b: 1'b1, sum: 1'b0, co: 1'b1, ov: 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;

    // Reset state
    #12;
    checks++;
    if ({busy8, done8, sum8, co8, ov8, st8} !== 14'd0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h co=%b ov=%b st=%0d, expected all 0",
               busy8, done8, sum8, co8, ov8, st8);
    end
    checks++;
    if ({busy1, done1, sum1, co1, ov1, st1} !== 7'd0) begin
      errors++;
      $display("FAIL reset1: got busy=%b done=%b sum=%b co=%b ov=%b st=%0d, expected all 0",
               busy1, done1, sum1, co1, ov1, st1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, WIDTH=8
    for (int i = 0; i < 4; i++) begin
      op8($sformatf("tbl8_%0d", i), tbl8[i].a, tbl8[i].b, tbl8[i].sub,
          {tbl8[i].sum, tbl8[i].co, tbl8[i].ov});
    end
    op8("sub_80_01", 8'h80, 8'h01, 1'b1, {8'h7F, 1'b1, 1'b1});

    // Exhaustive add, WIDTH=1
    for (int i = 0; i < 4; i++) begin
      op1(tbl1[i].a, tbl1[i].b, {tbl1[i].sum, tbl1[i].co, tbl1[i].ov});
    end

    // Start pulse and operand changes during RUN must be ignored
    begin
      logic ok;
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      exp8_q.push_back(model8(8'h12, 8'h34, 1'b0));
      ok = 1'b1;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        if (busy8 !== 1'b1 || done8 !== 1'b0) ok = 1'b0;
        if (n == 3) begin
          a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
        end
        if (n == 4) start8 = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL ignore_busy: busy not steady during RUN");
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b1) begin
        errors++;
        $display("FAIL ignore_done: got done=%b at start+9, expected 1", done8);
      end
      ok = 1'b1;
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if (busy8 !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL ignore_extra: got busy=1 after completion, expected idle");
      end
    end

    // Back-to-back: start held high through DONE
    begin
      logic ok;
      @(negedge clk);
      a8 = 8'h21; b8 = 8'h13; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1 a8 = 8'h40; b8 = 8'h50; sub8 = 1'b1;
      exp8_q.push_back(model8(8'h21, 8'h13, 1'b0));
      ok = 1'b1;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        if (busy8 !== 1'b1 || done8 !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_busy1: busy not high for first operation");
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b1 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_done1: got done=%b busy=%b, expected 1/0", done8, busy8);
      end
      exp8_q.push_back(model8(8'h40, 8'h50, 1'b1));
      @(posedge clk);
      #1 start8 = 1'b0;
      lat_check8("b2b_second");
    end

    // Reset mid-RUN aborts the operation
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, co8, ov8, st8} !== 14'd0) begin
      errors++;
      $display("FAIL reset_midrun: got busy=%b done=%b sum=%h co=%b ov=%b st=%0d, expected all 0",
               busy8, done8, sum8, co8, ov8, st8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op8("after_reset", 8'h03, 8'h04, 1'b0, {8'h07, 1'b0, 1'b0});

    // Random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      logic [7:0] ra, rb;
      logic       rs;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      op8($sformatf("rand_%0d", i), ra, rb, rs, model8(ra, rb, rs));
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp8_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending results, expected 0/0",
               exp8_q.size(), exp1_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be legal for any WIDTH >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 sub  input  1  mode: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  WIDTH  operand A, unsigned/two's-complement; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 sum  output  WIDTH  result of the last completed operation.
REQ-011 carry_out  output  1  final carry (add) or not-borrow (sub: 1 when a >= b unsigned).
REQ-012 overflow  output  1  signed overflow of the last completed operation.

Function
REQ-013 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch a, b (b inverted when sub=1) and sub, set internal carry to sub, clear the bit counter, and go to RUN.
REQ-015 RUN SHALL process exactly one bit per cycle, LSB first: sum bit = a_i ^ b'_i ^ c; c <= majority(a_i, b'_i, c).
REQ-016 Result bits SHALL be shifted into an internal result register; sum SHALL NOT change until the operation completes.
REQ-017 After WIDTH RUN cycles the FSM SHALL enter DONE for exactly one cycle and then return to IDLE unless a new start is accepted.
REQ-018 Latency: with start accepted at edge k, busy SHALL be 1 during cycles k+1..k+WIDTH, and done SHALL be 1 during cycle k+WIDTH+1 only.
REQ-019 sum, carry_out and overflow SHALL update at the edge entering DONE and hold until the next operation completes.
REQ-020 overflow SHALL equal (carry into MSB) XOR (carry out of MSB); for WIDTH=1 it SHALL be carry-in XOR carry-out of bit 0.
REQ-021 start SHALL be ignored while in RUN; latched operands SHALL NOT change when a/b/sub change during RUN.
REQ-022 start=1 in DONE SHALL be accepted (back-to-back): done pulses that cycle and busy rises the next cycle.
REQ-023 busy and done SHALL never be 1 simultaneously.
REQ-024 All arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, and clear the internal carry and counter.
REQ-026 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow, and the partial result SHALL be discarded.
REQ-027 After rst_n deasserts, the first start SHALL be accepted at the first rising edge where it is sampled high.

Verification
REQ-028 WIDTH=8, add 0x0F+0x01 -> sum=0x10, carry_out=0, overflow=0, done high exactly 9 cycles after the start edge.
REQ-029 WIDTH=8, add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0; add 0x7F+0x01 -> sum=0x80, carry_out=0, overflow=1.
REQ-030 WIDTH=8, sub 0x05-0x07 -> sum=0xFE, carry_out=0, overflow=0; sub 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1.
REQ-031 WIDTH=1, exhaustive add: (0,0)->sum 0/carry 0; (0,1) and (1,0)->sum 1/carry 0; (1,1)->sum 0/carry 1; done at start edge +2.
REQ-032 start pulsed and a/b changed during RUN -> result matches the originally latched operands, no extra operation; start held high in DONE -> back-to-back result correct.
REQ-033 rst_n pulsed low mid-RUN -> all outputs 0 immediately, no done pulse; next operation 0x03+0x04 -> sum=0x07.
